// File: rtl/cell_frame_renderer_if.sv
// Instruction bus between the drawing-command source and cell_frame_renderer.
interface cell_frame_renderer_if;
    logic [31:0] i_instruction;
    logic        i_instruction_ready;
    logic        o_busy;

    modport master (output i_instruction, output i_instruction_ready, input o_busy);
    modport slave  (input i_instruction, input i_instruction_ready, output o_busy);
endinterface

// File: rtl/cell_frame_renderer.sv
// Cell framebuffer feeding the VGA generator colour input; executes write/fill drawing instructions.
// Optional blinking inverse cursor enabled by defining CURSOR_EN.
module cell_frame_renderer #(
    parameter int unsigned COLS           = 32,
    parameter int unsigned ROWS           = 24,
    parameter int unsigned LINES_PER_CELL = 20
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_screen_reset,
    input  logic                  i_pixel_x_clock,
    input  logic                  i_pixel_y_clock,
    output logic [11:0]           o_color,
    cell_frame_renderer_if.slave  bus
);
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ADDR_W = COL_W + ROW_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned LINE_W = 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROW   = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;

    localparam logic [3:0] OP_WRITE_CELL = 4'h1;
    localparam logic [3:0] OP_FILL_ROW   = 4'h2;
    localparam logic [3:0] OP_FILL_FRAME = 4'h3;

    logic [11:0]       r_mem [DEPTH];
    logic [1:0]        r_state;
    logic              r_busy;
    logic [COL_W-1:0]  r_fill_col;
    logic [ROW_W-1:0]  r_fill_row;
    logic [11:0]       r_fill_color;
    logic              r_wc_pend;
    logic [ADDR_W-1:0] r_wc_addr;
    logic [11:0]       r_wc_color;
    logic [COL_W:0]    r_col;
    logic [ROW_W-1:0]  r_row;
    logic [LINE_W-1:0] r_line;

    logic [1:0]        w_state_next;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [11:0]       w_wdata;
    logic [3:0]        w_op;
    logic [4:0]        w_x;
    logic [4:0]        w_y;
    logic [11:0]       w_icolor;
    logic              w_x_ok;
    logic              w_y_ok;
    logic              w_accept;
    logic              w_fill_last_col;
    logic              w_col_in;
    logic [ADDR_W-1:0] w_raddr;
    logic [11:0]       w_ram;
    logic [11:0]       w_pix;
    logic              w_unused;

    assign w_op     = bus.i_instruction[31:28];
    assign w_x      = bus.i_instruction[27:23];
    assign w_y      = bus.i_instruction[22:18];
    assign w_icolor = bus.i_instruction[11:0];
    assign w_x_ok   = 32'(w_x) < COLS;
    assign w_y_ok   = 32'(w_y) < ROWS;
    assign w_accept = bus.i_instruction_ready && (r_state == S_IDLE);
    assign w_fill_last_col = (r_fill_col == COL_W'(COLS - 1));
    assign bus.o_busy = r_busy;

    // Next state and RAM write port; a pending single-cell write only occurs in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = '0;
        w_wdata      = r_fill_color;
        case (r_state)
            S_IDLE: begin
                if (r_wc_pend) begin
                    w_we    = 1'b1;
                    w_waddr = r_wc_addr;
                    w_wdata = r_wc_color;
                end
                if (w_accept && (w_op == OP_FILL_ROW) && w_y_ok) begin
                    w_state_next = S_ROW;
                end else if (w_accept && (w_op == OP_FILL_FRAME)) begin
                    w_state_next = S_FRAME;
                end
            end
            S_ROW: begin
                w_we    = 1'b1;
                w_waddr = {r_fill_row, r_fill_col};
                if (w_fill_last_col) w_state_next = S_IDLE;
            end
            S_FRAME: begin
                w_we    = 1'b1;
                w_waddr = {r_fill_row, r_fill_col};
                if (w_fill_last_col && (r_fill_row == ROW_W'(ROWS - 1))) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    // Fill address counters and the one-shot WRITE_CELL latch.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fill_col   <= '0;
            r_fill_row   <= '0;
            r_fill_color <= '0;
            r_wc_pend    <= 1'b0;
            r_wc_addr    <= '0;
            r_wc_color   <= '0;
        end else begin
            r_wc_pend  <= w_accept && (w_op == OP_WRITE_CELL) && w_x_ok && w_y_ok;
            r_wc_addr  <= {w_y[ROW_W-1:0], w_x[COL_W-1:0]};
            r_wc_color <= w_icolor;
            if (w_accept) begin
                r_fill_col   <= '0;
                r_fill_row   <= (w_op == OP_FILL_ROW) ? w_y[ROW_W-1:0] : '0;
                r_fill_color <= w_icolor;
            end else if (r_state != S_IDLE) begin
                r_fill_col <= r_fill_col + COL_W'(1);
                if ((r_state == S_FRAME) && w_fill_last_col) r_fill_row <= r_fill_row + ROW_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    assign w_col_in = 32'(r_col) < COLS;
    assign w_raddr  = {r_row, r_col[COL_W-1:0]};
    assign w_ram    = r_mem[w_raddr];

`ifdef CURSOR_EN
    logic [4:0] r_cur_x;
    logic [4:0] r_cur_y;
    logic       r_cur_en;
    logic [5:0] r_frame_cnt;
    logic       w_cursor_hit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_cur_en    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (i_screen_reset) r_frame_cnt <= r_frame_cnt + 6'd1;
            if (w_accept && (w_op == 4'h4)) begin
                r_cur_x  <= w_x;
                r_cur_y  <= w_y;
                r_cur_en <= bus.i_instruction[17];
            end
        end
    end

    assign w_cursor_hit = r_cur_en && r_frame_cnt[5] &&
                          (32'(r_col) == 32'(r_cur_x)) && (32'(r_row) == 32'(r_cur_y));
    assign w_pix    = w_cursor_hit ? ~w_ram : w_ram;
    assign w_unused = ^bus.i_instruction[16:12];
`else
    assign w_pix    = w_ram;
    assign w_unused = ^bus.i_instruction[17:12];
`endif

    // Beam tracking: screen_reset beats pixel_y beats pixel_x.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_col   <= '0;
            r_row   <= '0;
            r_line  <= '0;
            o_color <= '0;
        end else if (i_screen_reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_line <= '0;
        end else if (i_pixel_y_clock) begin
            r_col <= '0;
            if (r_line == LINE_W'(LINES_PER_CELL - 1)) begin
                r_line <= '0;
                if (r_row < ROW_W'(ROWS - 1)) r_row <= r_row + ROW_W'(1);
            end else begin
                r_line <= r_line + LINE_W'(1);
            end
        end else if (i_pixel_x_clock) begin
            if (w_col_in) begin
                o_color <= w_pix;
                r_col   <= r_col + (COL_W + 1)'(1);
            end else begin
                o_color <= '0;
            end
        end
    end
endmodule
